// File: rtl/alu_pkg.sv
// Shared definitions for the ALU initiator controller.
//   - ALU op code constants (add/sub/mul/div; codes with bit 2 set are unsupported)
//   - controller FSM state encoding
//   - settle counter and statistics counter widths
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } ctrl_state_e;

  // Settle counter holds SETTLE_CYCLES-1, so 4 bits cover the legal range 1..15.
  localparam int unsigned CNT_WIDTH  = 4;
  localparam int unsigned STAT_WIDTH = 16;

  // Op codes 100-111 have no ALU implementation behind them.
  function automatic logic op_unsupported(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_ctrl_stats.sv
// Saturating retire/error counters for the ALU controller.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   retire              a response is retired this cycle (rsp_valid && rsp_ready)
//   retire_err          the retiring response carries an error
//   stat_ops            count of retired responses, saturates at all-ones
//   stat_errs           count of retired error responses, saturates at all-ones
module alu_ctrl_stats
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  retire,
  input  logic                  retire_err,
  output logic [STAT_WIDTH-1:0] stat_ops,
  output logic [STAT_WIDTH-1:0] stat_errs
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else begin
      if (retire && (stat_ops != '1)) begin
        stat_ops <= stat_ops + 1'b1;
      end
      if (retire && retire_err && (stat_errs != '1)) begin
        stat_errs <= stat_errs + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Initiator-side controller for the combinational ALU.
// Takes requests on a valid/ready channel, drives the ALU from registers, holds them for
// SETTLE_CYCLES cycles, then captures result/zero/error onto a valid/ready response channel.
// Optional feature: define ALU_CTRL_STATS_EN to add the stat_ops/stat_errs counters.
// Ports:
//   clk, rst                                  clock, asynchronous active-high reset
//   req_valid/req_ready/req_a/req_b/req_op/req_poison   request channel
//   alu_in0/alu_in1/alu_op/alu_nvalid_data    registered ALU drive
//   alu_out/alu_zero/alu_error                ALU outputs
//   rsp_valid/rsp_ready/rsp_result/rsp_zero/rsp_error/rsp_op   response channel
//   stat_ops/stat_errs                        (ALU_CTRL_STATS_EN only) retire counters
// SETTLE_CYCLES must lie in 1..15.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WIDTH-1:0]      req_a,
  input  logic [WIDTH-1:0]      req_b,
  input  logic [2:0]            req_op,
  input  logic                  req_poison,
  output logic [WIDTH-1:0]      alu_in0,
  output logic [WIDTH-1:0]      alu_in1,
  output logic [2:0]            alu_op,
  output logic                  alu_nvalid_data,
  input  logic [2*WIDTH-1:0]    alu_out,
  input  logic                  alu_zero,
  input  logic                  alu_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_error,
  output logic [2:0]            rsp_op
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_ops,
  output logic [STAT_WIDTH-1:0] stat_errs
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(SETTLE_CYCLES - 1);

  ctrl_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 load;     // latch a new request into the ALU drive registers
  logic                 capture;  // sample the ALU outputs into the response registers
  logic                 retire;   // response handed off this cycle
  logic                 err;

  // Unsupported ops are flagged here so the undriven ALU output never leaks out.
  assign err = alu_error | op_unsupported(alu_op);

  assign rsp_valid = (state_q == StResp);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load    = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        // A new request may load on the same edge the response retires.
        req_ready = rsp_ready;
        if (rsp_ready) begin
          retire = 1'b1;
          if (req_valid) begin
            load    = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      cnt_d = CNT_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU drive registers: nvalid_data stays high whenever nothing is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in0         <= '0;
      alu_in1         <= '0;
      alu_op          <= '0;
      alu_nvalid_data <= 1'b1;
    end else if (load) begin
      alu_in0         <= req_a;
      alu_in1         <= req_b;
      alu_op          <= req_op;
      alu_nvalid_data <= req_poison;
    end else if (retire) begin
      alu_nvalid_data <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_op     <= '0;
    end else if (capture) begin
      rsp_result <= err ? '0 : alu_out;
      rsp_zero   <= err ? 1'b0 : alu_zero;
      rsp_error  <= err;
      rsp_op     <= alu_op;
    end
  end

`ifdef ALU_CTRL_STATS_EN
  alu_ctrl_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .retire    (retire),
    .retire_err(rsp_error),
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
  );
`endif

endmodule
